uart_tx_frame_engine: RTL and testbench

- Parametrised UART transmit engine for the UART_TX path; replaces the fixed 8-bit serializer, parity and output-select trio.
- Latches a parallel word and configuration, then emits a frame on TX_OUT at one bit per CLK: start, DATA_WIDTH data bits LSB-first, optional parity, STOP_BITS stop bits.
- CLK is the TX (baud) clock from the clock divider.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_parity_calc.sv | 17 +
 rtl/uart_tx_frame_engine.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_frame_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame engine.
package uart_tx_pkg;

    // Frame FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // TX output bit-select codes.
    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    // Parity type encodings as seen on PAR_TYP.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of a DATA_WIDTH word: even = XOR of all bits, odd = its inverse.
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    // Reduce the word and invert for odd parity.
    always_comb begin
        parity_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);
    end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: start, DATA_WIDTH data bits LSB-first, optional parity,
// STOP_BITS stop bits, one bit per CLK. TX_OUT and Busy are registered from the next state.
// Optional build macro UART_TX_HOLD_REG_EN adds a one-entry holding register and HOLD_FULL.
module uart_tx_frame_engine
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
`ifdef UART_TX_HOLD_REG_EN
    output logic                  HOLD_FULL,
`endif
    output logic                  Busy
);

    // Counter indexes data bits directly, so its width matches the data index width.
    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [1:0]            sel_d;
    logic                  par_in;

`ifdef UART_TX_HOLD_REG_EN
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_par_en_q, hold_par_en_d;
    logic                  hold_par_bit_q, hold_par_bit_d;
`endif

    // Parity is taken from the inputs at latch time and stored with the word.
    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i     (P_DATA),
        .par_typ_i  (PAR_TYP),
        .parity_o   (par_in)
    );

    // Next-state, bit counter and latch updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`ifdef UART_TX_HOLD_REG_EN
        hold_full_d    = hold_full_q;
        hold_data_d    = hold_data_q;
        hold_par_en_d  = hold_par_en_q;
        hold_par_bit_d = hold_par_bit_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef UART_TX_HOLD_REG_EN
                // A word captured on the final stop edge drains here; new requests drop.
                if (hold_full_q) begin
                    state_d     = START;
                    data_d      = hold_data_q;
                    par_en_d    = hold_par_en_q;
                    par_bit_d   = hold_par_bit_q;
                    hold_full_d = 1'b0;
                end else
`endif
                if (Data_Valid) begin
                    state_d   = START;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = par_in;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                state_d = STOP;
                cnt_d   = '0;
            end
            STOP: begin
                if (cnt_q == CntW'(STOP_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef UART_TX_HOLD_REG_EN
                    if (hold_full_q) begin
                        state_d     = START;
                        data_d      = hold_data_q;
                        par_en_d    = hold_par_en_q;
                        par_bit_d   = hold_par_bit_q;
                        hold_full_d = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef UART_TX_HOLD_REG_EN
        // Holding slot only accepts while a frame is on the line and the slot is empty.
        if (busy_q && !hold_full_q && Data_Valid) begin
            hold_full_d    = 1'b1;
            hold_data_d    = P_DATA;
            hold_par_en_d  = PAR_EN;
            hold_par_bit_d = par_in;
        end
`endif
    end

    // Output bit select and registered-output next values, derived from the next state.
    always_comb begin
        unique case (state_d)
            START:   sel_d = SEL_START;
            DATA:    sel_d = SEL_DATA;
            PARITY:  sel_d = SEL_PAR;
            default: sel_d = SEL_STOP;
        endcase
        unique case (sel_d)
            SEL_START: tx_d = 1'b0;
            SEL_DATA:  tx_d = data_d[cnt_d];
            SEL_PAR:   tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_TX_HOLD_REG_EN
    // Holding register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_full_q    <= 1'b0;
            hold_data_q    <= '0;
            hold_par_en_q  <= 1'b0;
            hold_par_bit_q <= 1'b0;
        end else begin
            hold_full_q    <= hold_full_d;
            hold_data_q    <= hold_data_d;
            hold_par_en_q  <= hold_par_en_d;
            hold_par_bit_q <= hold_par_bit_d;
        end
    end

    assign HOLD_FULL = hold_full_q;
`endif

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Scoreboard bench: two engines (STOP_BITS 1 and 2) share stimulus; expected line bits and
// Busy run lengths are queued by the stimulus and consumed by a negedge monitor.
module tb_uart_tx_frame_engine;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [1:0] tx_w;
    logic [1:0] busy_w;
`ifdef UART_TX_HOLD_REG_EN
    logic [1:0] hold_w;
`endif

    int checks   = 0;
    int failures = 0;

    bit exp_bits [2][$];
    int exp_len  [2][$];
    int run      [2];

    always #5 CLK = ~CLK;

    uart_tx_frame_engine #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (tx_w[0]),
`ifdef UART_TX_HOLD_REG_EN
        .HOLD_FULL  (hold_w[0]),
`endif
        .Busy       (busy_w[0])
    );

    uart_tx_frame_engine #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (tx_w[1]),
`ifdef UART_TX_HOLD_REG_EN
        .HOLD_FULL  (hold_w[1]),
`endif
        .Busy       (busy_w[1])
    );

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch%0d: got %0d, expected %0d at %0t", name, c, act, exp, $time);
        end
    endtask

    // Queue one expected frame per selected channel; extend merges it into the previous Busy run.
    task automatic push_frame(input logic [7:0] d, input bit en, input bit par,
                              input bit [1:0] mask, input bit extend);
        for (int c = 0; c < 2; c++) begin
            if (mask[c]) begin
                int len;
                exp_bits[c].push_back(1'b0);
                for (int i = 0; i < 8; i++) exp_bits[c].push_back(d[i]);
                if (en) exp_bits[c].push_back(par);
                for (int s = 0; s < c + 1; s++) exp_bits[c].push_back(1'b1);
                len = 1 + 8 + (en ? 1 : 0) + c + 1;
                if (extend && exp_len[c].size() > 0)
                    exp_len[c][exp_len[c].size() - 1] = exp_len[c][exp_len[c].size() - 1] + len;
                else
                    exp_len[c].push_back(len);
            end
        end
    endtask

    // Called at posedge+1; the request is sampled on the next rising edge.
    task automatic pulse(input logic [7:0] d, input logic en, input logic typ);
        P_DATA     = d;
        PAR_EN     = en;
        PAR_TYP    = typ;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_w != 2'b00 && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("idle_timeout", 0, {30'd0, busy_w}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // Monitor: compare line bits while Busy, idle-high otherwise, and Busy run lengths.
    always @(negedge CLK) begin
        for (int c = 0; c < 2; c++) begin
            if (!RST) begin
                chk("reset_tx", c, {31'd0, tx_w[c]}, 32'd1);
                chk("reset_busy", c, {31'd0, busy_w[c]}, 32'd0);
                run[c] = 0;
            end else if (busy_w[c]) begin
                if (exp_bits[c].size() == 0) begin
                    chk("unexpected_busy", c, 32'd1, 32'd0);
                end else begin
                    bit b;
                    b = exp_bits[c].pop_front();
                    chk("tx_bit", c, {31'd0, tx_w[c]}, {31'd0, b});
                end
                run[c]++;
            end else begin
                chk("idle_tx", c, {31'd0, tx_w[c]}, 32'd1);
                if (run[c] != 0) begin
                    if (exp_len[c].size() == 0) chk("unexpected_frame", c, run[c], 32'd0);
                    else chk("busy_len", c, run[c], exp_len[c].pop_front());
                    run[c] = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vd  [6] = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'hFF, 8'h7F};
        bit         ven [6] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
        bit         vty [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        bit         vpar[6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};

        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        run[0]     = 0;
        run[1]     = 0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1;

        // Directed frames with hand-computed parity.
        for (int i = 0; i < 6; i++) begin
            push_frame(vd[i], ven[i], vpar[i], 2'b11, 1'b0);
            pulse(vd[i], ven[i], vty[i]);
            wait_idle();
        end

`ifndef UART_TX_HOLD_REG_EN
        // Mid-frame input changes and a request while busy must not disturb the frame.
        push_frame(8'hA5, 1'b1, 1'b0, 2'b11, 1'b0);
        pulse(8'hA5, 1'b1, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        P_DATA     = 8'h3C;
        PAR_TYP    = 1'b1;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
        P_DATA = 8'hFF;
        wait_idle();

        // Data_Valid held high for 13 edges: ch0 sends two frames with one idle cycle
        // between them; ch1 is still in its last stop bit at the 13th edge.
        push_frame(8'h3C, 1'b1, 1'b0, 2'b11, 1'b0);
        push_frame(8'h3C, 1'b1, 1'b0, 2'b01, 1'b0);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        repeat (13) @(posedge CLK);
        #1 Data_Valid = 1'b0;
        wait_idle();
`endif

        // Reset during DATA with cnt=3 abandons the frame at once.
        push_frame(8'hA5, 1'b1, 1'b0, 2'b11, 1'b0);
        pulse(8'hA5, 1'b1, 1'b0);
        repeat (4) @(posedge CLK);
        #1 RST = 1'b0;
        for (int c = 0; c < 2; c++) begin
            exp_bits[c].delete();
            exp_len[c].delete();
        end
        #1;
        for (int c = 0; c < 2; c++) begin
            chk("async_rst_tx", c, {31'd0, tx_w[c]}, 32'd1);
            chk("async_rst_busy", c, {31'd0, busy_w[c]}, 32'd0);
        end
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        push_frame(8'h55, 1'b1, 1'b0, 2'b11, 1'b0);
        pulse(8'h55, 1'b1, 1'b0);
        wait_idle();

`ifdef UART_TX_HOLD_REG_EN
        // Back-to-back through the holding register; a third request is dropped.
        push_frame(8'h11, 1'b1, 1'b0, 2'b11, 1'b0);
        push_frame(8'h22, 1'b1, 1'b0, 2'b11, 1'b1);
        pulse(8'h11, 1'b1, 1'b0);
        pulse(8'h22, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) chk("hold_full_set", c, {31'd0, hold_w[c]}, 32'd1);
        pulse(8'h33, 1'b1, 1'b0);
        wait_idle();
        for (int c = 0; c < 2; c++) chk("hold_full_clr", c, {31'd0, hold_w[c]}, 32'd0);
`endif

        for (int c = 0; c < 2; c++) begin
            chk("bits_left", c, exp_bits[c].size(), 32'd0);
            chk("frames_left", c, exp_len[c].size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
